instr_decode_ctrl: RTL and testbench

- Multi-cycle fetch/decode controller directly upstream of the register-file/ALU datapath.
- Fetches 16-bit instruction words from instruction memory over a request/valid handshake and decodes each word.
- Drives the datapath's register addresses, ALU opcode, immediate, immediate-select and write-enable, one instruction at a time.
- Maintains the program counter and halts on a HALT instruction.

---
 rtl/instr_decode_ctrl_if.sv | 35 +++
 rtl/instr_decode_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_instr_decode_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_ctrl_if.sv
// Instruction-memory handshake plus the decoded control bundle that the
// fetch/decode controller drives into the register-file/ALU datapath.
interface instr_decode_ctrl_if #(
    parameter int unsigned PCW = 8
);
    logic [PCW-1:0] IMemAddr;
    logic           IMemRd;
    logic [15:0]    IMemData;
    logic           IMemValid;
    logic [3:0]     RdestRegLoc;
    logic [3:0]     RsrcRegLoc;
    logic [4:0]     OpCode;
    logic [15:0]    Imm;
    logic           Imm_s;
    logic           En;
    logic           FlagEn;
    logic           Illegal;
    logic           Halted;

    // Controller side: owns the memory request and the decoded outputs.
    modport master (
        output IMemAddr, IMemRd,
        input  IMemData, IMemValid,
        output RdestRegLoc, RsrcRegLoc, OpCode, Imm, Imm_s,
        output En, FlagEn, Illegal, Halted
    );

    // Memory/datapath side.
    modport slave (
        input  IMemAddr, IMemRd,
        output IMemData, IMemValid,
        input  RdestRegLoc, RsrcRegLoc, OpCode, Imm, Imm_s,
        input  En, FlagEn, Illegal, Halted
    );
endinterface

// File: rtl/instr_decode_ctrl.sv
// Multi-cycle fetch/decode controller: fetches 16-bit words, decodes them
// into register indices, ALU opcode and immediate, pulses the write/flag
// enables in EXEC, advances the PC and stops on HALT.
module instr_decode_ctrl #(
    parameter int unsigned    PCW      = 8,
    parameter logic [PCW-1:0] RESET_PC = '0
) (
    input  logic                     Clk,
    input  logic                     Rst,
    instr_decode_ctrl_if.master      bus
);

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t         r_state;
    logic [PCW-1:0] r_pc;
    logic           r_imem_rd;
    logic [3:0]     r_rdest;
    logic [3:0]     r_rsrc;
    logic [4:0]     r_opcode;
    logic [15:0]    r_imm;
    logic           r_imm_s;
    logic           r_en;
    logic           r_flag_en;
    logic           r_illegal;
    logic           r_halted;
    // Classification of the latched word, consumed when entering EXEC.
    logic           r_pend_en;
    logic           r_pend_flag;
    logic           r_pend_illegal;
    logic           r_pend_halt;

    logic [15:0]    w_inst;
    logic [3:0]     w_rdest;
    logic [3:0]     w_rsrc;
    logic [4:0]     w_opcode;
    logic [15:0]    w_imm;
    logic           w_imm_s;
    logic           w_en;
    logic           w_flag;
    logic           w_illegal;
    logic           w_halt;

    assign w_inst = bus.IMemData;

    // Combinational decode of the incoming word; only used on the WAIT->DECODE edge.
    always_comb begin
        w_rdest   = 4'd0;
        w_rsrc    = 4'd0;
        w_opcode  = 5'd0;
        w_imm     = 16'd0;
        w_imm_s   = 1'b0;
        w_en      = 1'b0;
        w_flag    = 1'b0;
        w_illegal = 1'b0;
        w_halt    = 1'b0;
        case (w_inst[15:12])
            4'h0: begin
                // Register-register form; func selects the ALU op.
                w_rdest = w_inst[11:8];
                w_rsrc  = w_inst[3:0];
                case (w_inst[7:4])
                    4'h0: ;  // NOP: no enables
                    4'h5: begin w_opcode = 5'd0; w_en = 1'b1; w_flag = 1'b1; end
                    4'h9: begin w_opcode = 5'd1; w_en = 1'b1; w_flag = 1'b1; end
                    4'hB: begin w_opcode = 5'd2; w_flag = 1'b1; end
                    4'h1: begin w_opcode = 5'd3; w_en = 1'b1; end
                    4'h2: begin w_opcode = 5'd4; w_en = 1'b1; end
                    4'h3: begin w_opcode = 5'd5; w_en = 1'b1; end
                    4'h6: begin w_opcode = 5'd6; w_en = 1'b1; end
                    4'h4: begin w_opcode = 5'd7; w_en = 1'b1; end
                    4'h8: begin w_opcode = 5'd8; w_en = 1'b1; end
                    4'hA: begin w_opcode = 5'd9; w_en = 1'b1; end
                    default: begin
                        w_rdest   = 4'd0;
                        w_rsrc    = 4'd0;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            // Arithmetic immediates use a sign-extended imm8.
            4'h5: begin
                w_rdest = w_inst[11:8]; w_imm_s = 1'b1; w_opcode = 5'd0;
                w_imm = {{8{w_inst[7]}}, w_inst[7:0]}; w_en = 1'b1; w_flag = 1'b1;
            end
            4'h9: begin
                w_rdest = w_inst[11:8]; w_imm_s = 1'b1; w_opcode = 5'd1;
                w_imm = {{8{w_inst[7]}}, w_inst[7:0]}; w_en = 1'b1; w_flag = 1'b1;
            end
            4'hB: begin
                w_rdest = w_inst[11:8]; w_imm_s = 1'b1; w_opcode = 5'd2;
                w_imm = {{8{w_inst[7]}}, w_inst[7:0]}; w_flag = 1'b1;
            end
            // Logical immediates use a zero-extended imm8.
            4'h1: begin
                w_rdest = w_inst[11:8]; w_imm_s = 1'b1; w_opcode = 5'd3;
                w_imm = {8'h00, w_inst[7:0]}; w_en = 1'b1;
            end
            4'h2: begin
                w_rdest = w_inst[11:8]; w_imm_s = 1'b1; w_opcode = 5'd4;
                w_imm = {8'h00, w_inst[7:0]}; w_en = 1'b1;
            end
            4'h3: begin
                w_rdest = w_inst[11:8]; w_imm_s = 1'b1; w_opcode = 5'd5;
                w_imm = {8'h00, w_inst[7:0]}; w_en = 1'b1;
            end
            4'hF: begin
                if (w_inst[11:0] == 12'h000) begin
                    w_halt = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Control FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state        <= S_START;
            r_pc           <= RESET_PC;
            r_imem_rd      <= 1'b0;
            r_rdest        <= 4'd0;
            r_rsrc         <= 4'd0;
            r_opcode       <= 5'd0;
            r_imm          <= 16'd0;
            r_imm_s        <= 1'b0;
            r_en           <= 1'b0;
            r_flag_en      <= 1'b0;
            r_illegal      <= 1'b0;
            r_halted       <= 1'b0;
            r_pend_en      <= 1'b0;
            r_pend_flag    <= 1'b0;
            r_pend_illegal <= 1'b0;
            r_pend_halt    <= 1'b0;
        end else begin
            r_imem_rd <= 1'b0;
            r_en      <= 1'b0;
            r_flag_en <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_START: begin
                    r_state   <= S_FETCH;
                    r_imem_rd <= 1'b1;
                end
                S_FETCH: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.IMemValid) begin
                        r_state        <= S_DECODE;
                        r_rdest        <= w_rdest;
                        r_rsrc         <= w_rsrc;
                        r_opcode       <= w_opcode;
                        r_imm          <= w_imm;
                        r_imm_s        <= w_imm_s;
                        r_pend_en      <= w_en;
                        r_pend_flag    <= w_flag;
                        r_pend_illegal <= w_illegal;
                        r_pend_halt    <= w_halt;
                    end
                end
                S_DECODE: begin
                    r_state   <= S_EXEC;
                    r_en      <= r_pend_en;
                    r_flag_en <= r_pend_flag;
                    r_illegal <= r_pend_illegal;
                end
                S_EXEC: begin
                    if (r_pend_halt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state   <= S_FETCH;
                        r_pc      <= r_pc + 1'b1;
                        r_imem_rd <= 1'b1;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_START;
                end
            endcase
        end
    end

    assign bus.IMemAddr    = r_pc;
    assign bus.IMemRd      = r_imem_rd;
    assign bus.RdestRegLoc = r_rdest;
    assign bus.RsrcRegLoc  = r_rsrc;
    assign bus.OpCode      = r_opcode;
    assign bus.Imm         = r_imm;
    assign bus.Imm_s       = r_imm_s;
    assign bus.En          = r_en;
    assign bus.FlagEn      = r_flag_en;
    assign bus.Illegal     = r_illegal;
    assign bus.Halted      = r_halted;

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Bench for instr_decode_ctrl: directed vector table, randomized words
// checked against a table-lookup decode model, reset/stall/halt/PC-wrap sequences.
module tb_instr_decode_ctrl;

    typedef struct {
        logic [15:0] word;
        int          wait_n;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [4:0]  op;
        logic [15:0] imm;
        logic        imm_s;
        logic        en;
        logic        fl;
        logic        ill;
        logic        halt;
        logic        chk_regs;
        logic        chk_op;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   txn = 0;
    logic [7:0] exp_pc = 8'h00;

    always #5 clk = ~clk;

    instr_decode_ctrl_if #(.PCW(8)) ifc ();
    instr_decode_ctrl_if #(.PCW(8)) ifc2 ();

    instr_decode_ctrl #(.PCW(8), .RESET_PC(8'h00)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (ifc)
    );

    instr_decode_ctrl #(.PCW(8), .RESET_PC(8'hFF)) dut2 (
        .Clk (clk),
        .Rst (rst),
        .bus (ifc2)
    );

    // Second instance is fed a permanent stream of NOPs.
    initial begin
        ifc2.IMemValid = 1'b1;
        ifc2.IMemData  = 16'h0000;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [15:0] w, input int wn, input logic [3:0] rd,
                                input logic [3:0] rs, input logic [4:0] op, input logic [15:0] imm,
                                input logic s, input logic en, input logic fl, input logic ill,
                                input logic halt, input logic cregs, input logic cop);
        vec_t v;
        v.word = w; v.wait_n = wn; v.rd = rd; v.rs = rs; v.op = op; v.imm = imm;
        v.imm_s = s; v.en = en; v.fl = fl; v.ill = ill; v.halt = halt;
        v.chk_regs = cregs; v.chk_op = cop;
        return v;
    endfunction

    // Reference decode: look the mnemonic code up in the ALU op list; its
    // position in the list is the opcode. First three entries set flags,
    // CMP alone does not write, the first three immediates sign-extend.
    function automatic vec_t ref_decode(input logic [15:0] w, input int wn);
        logic [3:0] alu_code [10] = '{4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'h6, 4'h4, 4'h8, 4'hA};
        vec_t r;
        r = mk(w, wn, 4'd0, 4'd0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        if (w == 16'hF000) begin
            r.halt = 1'b1; r.chk_regs = 1'b0;
            return r;
        end
        if (w[15:12] == 4'h0) begin
            r.rd = w[11:8]; r.rs = w[3:0];
            if (w[7:4] == 4'h0) begin
                r.chk_op = 1'b0;
                return r;
            end
            for (int i = 0; i < 10; i++) begin
                if (alu_code[i] == w[7:4]) begin
                    r.op = 5'(i); r.en = (i != 2); r.fl = (i <= 2);
                    return r;
                end
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (alu_code[i] == w[15:12]) begin
                    r.rd = w[11:8]; r.imm_s = 1'b1; r.op = 5'(i);
                    r.imm = (i < 3 && w[7]) ? {8'hFF, w[7:0]} : {8'h00, w[7:0]};
                    r.en = (i != 2); r.fl = (i <= 2);
                    return r;
                end
            end
        end
        r.ill = 1'b1; r.chk_regs = 1'b0; r.rd = 4'd0; r.rs = 4'd0;
        return r;
    endfunction

    // Assert reset asynchronously between edges, check cleared outputs,
    // release, then expect START followed by a FETCH with IMemRd high.
    // Returns right after the negedge inside FETCH.
    task automatic do_reset();
        ifc.IMemValid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_ctrl", {ifc.IMemRd, ifc.En, ifc.FlagEn, ifc.Illegal, ifc.Halted, ifc.Imm_s}, 64'd0);
        check("rst_fields", {ifc.RdestRegLoc, ifc.RsrcRegLoc, ifc.OpCode, ifc.Imm}, 64'd0);
        check("rst_addr", ifc.IMemAddr, 64'h00);
        @(negedge clk);
        rst = 1'b0;
        check("start_no_rd", ifc.IMemRd, 64'd0);
        @(negedge clk);
        check("fetch_rd_after_rst", ifc.IMemRd, 64'd1);
        exp_pc = 8'h00;
    endtask

    // Runs one instruction from a FETCH negedge to the following FETCH/HALT negedge.
    task automatic run_vec(input vec_t v);
        check("fetch_rd", ifc.IMemRd, 64'd1);
        check("fetch_addr", ifc.IMemAddr, exp_pc);
        @(negedge clk);
        for (int k = 0; k < v.wait_n; k++) begin
            ifc.IMemValid = 1'b0;
            ifc.IMemData  = 16'($urandom);
            check("wait_stall", {ifc.IMemRd, ifc.En, ifc.FlagEn, ifc.IMemAddr}, {3'b000, exp_pc});
            @(negedge clk);
        end
        ifc.IMemValid = 1'b1;
        ifc.IMemData  = v.word;
        @(negedge clk);
        ifc.IMemValid = 1'($urandom_range(0, 1));
        ifc.IMemData  = 16'($urandom);
        check("decode_quiet", {ifc.En, ifc.FlagEn, ifc.Illegal, ifc.IMemRd}, 64'd0);
        @(negedge clk);
        ifc.IMemValid = 1'($urandom_range(0, 1));
        ifc.IMemData  = 16'($urandom);
        check("exec_en", ifc.En, v.en);
        check("exec_flag", ifc.FlagEn, v.fl);
        check("exec_illegal", ifc.Illegal, v.ill);
        check("exec_imm_s", ifc.Imm_s, v.imm_s);
        check("exec_halted", ifc.Halted, 64'd0);
        if (v.chk_op) check("exec_op", ifc.OpCode, v.op);
        if (v.chk_regs) check("exec_regs", {ifc.RdestRegLoc, ifc.RsrcRegLoc, ifc.Imm}, {v.rd, v.rs, v.imm});
        $display("txn %0d word=%04h addr=%02h rd=%0d rs=%0d op=%0d imm=%04h s=%0b en=%0b fl=%0b ill=%0b",
                 txn, v.word, ifc.IMemAddr, ifc.RdestRegLoc, ifc.RsrcRegLoc, ifc.OpCode,
                 ifc.Imm, ifc.Imm_s, ifc.En, ifc.FlagEn, ifc.Illegal);
        txn++;
        @(negedge clk);
        ifc.IMemValid = 1'($urandom_range(0, 1));
        ifc.IMemData  = 16'($urandom);
        check("pulse_end", {ifc.En, ifc.FlagEn, ifc.Illegal}, 64'd0);
        if (v.halt) begin
            check("halt_state", {ifc.Halted, ifc.IMemRd, ifc.IMemAddr}, {2'b10, exp_pc});
        end else begin
            if (v.chk_regs) check("fields_held", {ifc.RdestRegLoc, ifc.RsrcRegLoc, ifc.Imm}, {v.rd, v.rs, v.imm});
            exp_pc = exp_pc + 8'd1;
        end
    endtask

    vec_t tbl[$];

    initial begin
        logic [3:0]  tops [7] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB};
        logic [15:0] w;
        vec_t        v;

        //              word     wt rd    rs    op  imm       s  en fl ill hlt regs op
        tbl.push_back(mk(16'h0357, 0, 4'h3, 4'h7, 0, 16'h0000, 0, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(16'h52FF, 0, 4'h2, 4'h0, 0, 16'hFFFF, 1, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(16'h12FF, 0, 4'h2, 4'h0, 3, 16'h00FF, 1, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(16'h01B4, 1, 4'h1, 4'h4, 2, 16'h0000, 0, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(16'h0000, 0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(16'h0A65, 5, 4'hA, 4'h5, 6, 16'h0000, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(16'h7000, 0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(16'h9380, 2, 4'h3, 4'h0, 1, 16'hFF80, 1, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(16'hB47F, 0, 4'h4, 4'h0, 2, 16'h007F, 1, 0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(16'h3A0F, 0, 4'hA, 4'h0, 5, 16'h000F, 1, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(16'h2C80, 0, 4'hC, 4'h0, 4, 16'h0080, 1, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(16'h0D9E, 0, 4'hD, 4'hE, 1, 16'h0000, 0, 1, 1, 0, 0, 1, 1));
        tbl.push_back(mk(16'h0E4F, 0, 4'hE, 4'hF, 7, 16'h0000, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(16'h0C81, 0, 4'hC, 4'h1, 8, 16'h0000, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(16'h0FA2, 0, 4'hF, 4'h2, 9, 16'h0000, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(16'h0213, 0, 4'h2, 4'h3, 3, 16'h0000, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(16'h0324, 0, 4'h3, 4'h4, 4, 16'h0000, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(16'h0535, 0, 4'h5, 4'h5, 5, 16'h0000, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(16'hF001, 0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(16'h00C1, 0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(mk(16'h4123, 0, 4'h0, 4'h0, 0, 16'h0000, 0, 0, 0, 1, 0, 0, 1));

        ifc.IMemValid = 1'b0;
        ifc.IMemData  = 16'h0000;

        // Power-up reset; the RESET_PC=0xFF instance runs one NOP and must wrap to 0x00.
        do_reset();
        check("wrap_fetch0", {ifc2.IMemRd, ifc2.IMemAddr}, {1'b1, 8'hFF});
        repeat (3) @(negedge clk);
        check("wrap_exec_quiet", {ifc2.En, ifc2.FlagEn, ifc2.Illegal}, 64'd0);
        check("main_stuck_wait", {ifc.IMemRd, ifc.En, ifc.IMemAddr}, 64'd0);
        @(negedge clk);
        check("wrap_fetch1", {ifc2.IMemRd, ifc2.IMemAddr}, {1'b1, 8'h00});

        do_reset();
        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset while waiting on memory with non-zero decoded fields.
        run_vec(tbl[1]);
        @(negedge clk);
        do_reset();

        // Randomized words against the reference decode.
        for (int n = 0; n < 80; n++) begin
            w = 16'($urandom);
            case ($urandom_range(0, 3))
                0: w[15:12] = 4'h0;
                1: w[15:12] = tops[$urandom_range(0, 6)];
                default: ;
            endcase
            if (w == 16'hF000) w = 16'hF800;
            v = ref_decode(w, $urandom_range(0, 3));
            run_vec(v);
        end

        // HALT is terminal: no requests or pulses regardless of memory activity.
        v = ref_decode(16'hF000, 0);
        run_vec(v);
        for (int k = 0; k < 20; k++) begin
            ifc.IMemValid = 1'b1;
            ifc.IMemData  = 16'($urandom);
            @(negedge clk);
            check("halt_hold", {ifc.Halted, ifc.IMemRd, ifc.En, ifc.FlagEn, ifc.IMemAddr},
                  {4'b1000, exp_pc});
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
